// File: rtl/image_pkg.sv
// Shared types and constants for the frame streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: stream_state_t FSM encoding, default image geometry, TOTAL_BYTES,
// channel index constants, the 11-bit buffered byte word and the test-pattern
// byte function used when IMG_TEST_PATTERN_EN is defined.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    localparam int IMG_WIDTH    = 20;
    localparam int IMG_HEIGHT   = 20;
    localparam int IMG_CHANNELS = 3;
    localparam int TOTAL_BYTES  = IMG_WIDTH * IMG_HEIGHT * IMG_CHANNELS;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // Byte plus its frame/line markers; markers ride through the buffer with the byte.
    typedef struct packed {
        logic       eof;
        logic       eol;
        logic       sof;
        logic [7:0] data;
    } pix_word_t;

    localparam int PIX_WORD_W = $bits(pix_word_t);

    // Test-pattern byte; 8-bit arithmetic gives the mod-256 wrap for free.
    function automatic logic [7:0] pattern_byte(input logic [7:0] row,
                                                input logic [7:0] col,
                                                input logic [7:0] ch);
        return (col * 8'd8) + (row * 8'd4) + (ch * 8'd85);
    endfunction

endpackage

// File: rtl/image_stream_fifo2.sv
// 2-entry buffer between the frame-buffer read pipe and the pixel consumer.
// Latency: 1 cycle from push to out_vld_o; no combinational path from in to out.
// Backpressure: in_rdy_o low only when both entries hold data; out word holds while !out_rdy_i.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_vld_i/in_rdy_o    write handshake, in_dat_i payload
//   out_vld_o/out_rdy_i  read handshake, out_dat_o payload (head entry)
//   count_o              current occupancy 0..2
module image_stream_fifo2 #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [DW-1:0] in_dat_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [DW-1:0] out_dat_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          push;
    logic          pop;

    assign in_rdy_o  = (count_q != 2'd2);
    assign out_vld_o = (count_q != 2'd0);
    assign out_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    assign push = in_vld_i && in_rdy_o;
    assign pop  = out_vld_o && out_rdy_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/image_stream_tx.sv
// Streams a stored RGB frame from a synchronous frame-buffer RAM one byte per handshake.
// Latency: first pix_valid 2 cycles after start is sampled; then 1 byte/cycle while pix_ready.
// Backpressure: reads throttled so RAM reads in flight plus buffered bytes never exceed 2.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, pattern_en   begin frame (sampled in IDLE); select test pattern at start
//   mem_rd_en, mem_addr frame-buffer read strobe and byte address
//   mem_rd_data         RAM data, valid the cycle after mem_rd_en
//   pix_data/valid/ready output byte stream; pix_sof/eol/eof qualify the current byte
//   busy, done          busy from start accept to end of DONE; done = 1-cycle pulse
// Build option: define IMG_TEST_PATTERN_EN to include the internal pattern generator
// (pattern_en latched at start); without it pattern_en is ignored.
module image_stream_tx
    import image_pkg::*;
#(
    parameter int WIDTH    = IMG_WIDTH,
    parameter int HEIGHT   = IMG_HEIGHT,
    parameter int CHANNELS = IMG_CHANNELS,
    parameter int ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pattern_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam int CH_W  = $clog2(CHANNELS + 1);

    stream_state_t state_q, state_d;

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [CH_W-1:0]  ch_q,  ch_d;
    logic             rd_done_q, rd_done_d;

    // Read issued last cycle; its byte is on mem_rd_data (or in the pattern register) now.
    logic             inflight_q;
    logic             pend_sof_q, pend_eol_q, pend_eof_q;

    logic             start_acc;
    logic             issue;
    logic             pop;
    logic [2:0]       occ_after;
    logic             last_ch, last_col, last_row;
    logic             is_sof, is_eol, is_eof;

    logic             pat_mode;
    logic [7:0]       src_byte;

    pix_word_t        push_word;
    pix_word_t        head_word;
    logic [PIX_WORD_W-1:0] head_bits;
    logic             fifo_out_vld;
    logic [1:0]       fifo_count;
    logic             unused_fifo_in_rdy;

    assign start_acc = (state_q == IDLE) && start;
    assign pop       = fifo_out_vld && pix_ready;

    assign last_ch  = (ch_q  == CH_W'(CHANNELS - 1));
    assign last_col = (col_q == COL_W'(WIDTH - 1));
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    assign is_sof   = (row_q == '0) && (col_q == '0) && (ch_q == CH_W'(CH_R));
    assign is_eol   = last_ch && last_col;
    assign is_eof   = is_eol && last_row;

    // Occupancy the buffer will have once this cycle's pop and the in-flight byte land.
    // Issuing only while that is below 2 keeps 1 byte/cycle when draining and caps
    // outstanding reads plus buffered bytes at 2 when stalled.
    assign occ_after = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == STREAM) && !rd_done_q && (occ_after < 3'd2);

    assign mem_rd_en = issue && !pat_mode;
    assign mem_addr  = ((ADDR_W'(row_q) * ADDR_W'(WIDTH)) + ADDR_W'(col_q)) * ADDR_W'(CHANNELS)
                       + ADDR_W'(ch_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (pop && head_word.eof) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read counters: ch -> col -> row, one step per issued read
    // ------------------------------------------------------------------
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        ch_d      = ch_q;
        rd_done_d = rd_done_q;
        if (start_acc) begin
            row_d     = '0;
            col_d     = '0;
            ch_d      = '0;
            rd_done_d = 1'b0;
        end else if (issue) begin
            if (last_ch) begin
                ch_d = '0;
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        row_d     = '0;
                        rd_done_d = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            col_q      <= '0;
            ch_q       <= '0;
            rd_done_q  <= 1'b0;
            inflight_q <= 1'b0;
            pend_sof_q <= 1'b0;
            pend_eol_q <= 1'b0;
            pend_eof_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            ch_q       <= ch_d;
            rd_done_q  <= rd_done_d;
            inflight_q <= issue;
            if (issue) begin
                pend_sof_q <= is_sof;
                pend_eol_q <= is_eol;
                pend_eof_q <= is_eof;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte source: RAM, or the optional pattern generator
    // ------------------------------------------------------------------
`ifdef IMG_TEST_PATTERN_EN
    logic       pat_mode_q;
    logic [7:0] pat_byte_q;

    // Pattern byte is registered at issue so it lines up with where RAM data would arrive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_mode_q <= 1'b0;
            pat_byte_q <= 8'h00;
        end else begin
            if (start_acc) begin
                pat_mode_q <= pattern_en;
            end
            if (issue) begin
                pat_byte_q <= pattern_byte(8'(row_q), 8'(col_q), 8'(ch_q));
            end
        end
    end

    assign pat_mode = pat_mode_q;
    assign src_byte = pat_mode_q ? pat_byte_q : mem_rd_data;
`else
    logic unused_pattern_en;

    assign unused_pattern_en = pattern_en;
    assign pat_mode          = 1'b0;
    assign src_byte          = mem_rd_data;
`endif

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_comb begin
        push_word      = '0;
        push_word.eof  = pend_eof_q;
        push_word.eol  = pend_eol_q;
        push_word.sof  = pend_sof_q;
        push_word.data = src_byte;
    end

    image_stream_fifo2 #(
        .DW (PIX_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_vld_i  (inflight_q),
        .in_rdy_o  (unused_fifo_in_rdy),
        .in_dat_i  (push_word),
        .out_vld_o (fifo_out_vld),
        .out_rdy_i (pix_ready),
        .out_dat_o (head_bits),
        .count_o   (fifo_count)
    );

    assign head_word = pix_word_t'(head_bits);

    // Gate with valid so the idle stream reads as all-zero.
    assign pix_valid = fifo_out_vld;
    assign pix_data  = fifo_out_vld ? head_word.data : 8'h00;
    assign pix_sof   = fifo_out_vld && head_word.sof;
    assign pix_eol   = fifo_out_vld && head_word.eol;
    assign pix_eof   = fifo_out_vld && head_word.eof;

endmodule

// File: tb/tb_image_stream_tx.sv
module tb_image_stream_tx;
    import image_pkg::*;

    localparam int W = 20;
    localparam int H = 20;
    localparam int C = 3;
    localparam int N = W * H * C;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pattern_en;
    logic        mem_rd_en;
    logic [10:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof, pix_eol, pix_eof;
    logic        busy, done;

    always #5 clk = ~clk;

    image_stream_tx #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .ADDR_W(11)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_en(pattern_en),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    // Frame-buffer RAM: byte at address i holds i[7:0], one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    typedef struct packed {
        logic       eof;
        logic       eol;
        logic       sof;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   eof_edge = -1;
    bit   held_vld = 1'b0;
    exp_t held;

    always @(posedge clk) cyc = cyc + 1;

    function automatic exp_t model_byte(input int i, input bit pat);
        exp_t e;
        int row, col, ch;
        row = i / (W * C);
        col = (i / C) % W;
        ch  = i % C;
        e.data = pat ? 8'((col * 8 + row * 4 + ch * 85) % 256) : 8'(i % 256);
        e.sof  = (i == 0);
        e.eol  = ((i % (W * C)) == (W * C - 1));
        e.eof  = (i == N - 1);
        return e;
    endfunction

    task automatic push_frame(input bit pat);
        for (int i = 0; i < N; i++) sb.push_back(model_byte(i, pat));
    endtask

    // Scoreboard monitor: samples on the falling edge, i.e. the handshake about to complete.
    always @(negedge clk) begin
        exp_t obs, e;
        obs = {pix_eof, pix_eol, pix_sof, pix_data};
        if (reset) begin
            held_vld = 1'b0;
        end else begin
            if (mem_rd_en) rd_cnt = rd_cnt + 1;
            if (done) begin
                done_cnt = done_cnt + 1;
                checks = checks + 1;
                if (cyc !== eof_edge)
                    $display("FAIL done_timing: done at edge %0d, eof transferred at edge %0d", cyc, eof_edge);
                else passes = passes + 1;
            end
            if (held_vld) begin
                checks = checks + 1;
                if (!pix_valid || obs !== held)
                    $display("FAIL stall_hold: valid=%b word=%h, required valid=1 word=%h", pix_valid, obs, held);
                else passes = passes + 1;
            end
            if (pix_valid && pix_ready) begin
                xfer_cnt = xfer_cnt + 1;
                held_vld = 1'b0;
                if (pix_eof) eof_edge = cyc + 1;
                checks = checks + 1;
                if (sb.size() == 0) begin
                    $display("FAIL sb_extra: unexpected byte word=%h", obs);
                end else begin
                    e = sb.pop_front();
                    if (obs !== e)
                        $display("FAIL sb_byte: got eof/eol/sof/data=%h, expected %h", obs, e);
                    else passes = passes + 1;
                end
            end else if (pix_valid) begin
                held_vld = 1'b1;
                held = obs;
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pix_valid, pix_sof, pix_eol, pix_eof, mem_rd_en, busy, done} !== 7'b0)
            $display("FAIL reset_ctrl: got %b, required 0000000", {pix_valid, pix_sof, pix_eol, pix_eof, mem_rd_en, busy, done});
        else passes++;
        checks++;
        if (pix_data !== 8'h00 || mem_addr !== 11'h000)
            $display("FAIL reset_data: data=%h addr=%h, required 00/000", pix_data, mem_addr);
        else passes++;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || mem_rd_en !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b valid=%b rd_en=%b, required 0", busy, pix_valid, mem_rd_en);
        else passes++;
    endtask

    task automatic test_basic_frame();
        int rd0, dn0, x0;
        bit ok;
        rd0 = rd_cnt; dn0 = done_cnt; x0 = xfer_cnt;
        pix_ready = 1'b1;
        push_frame(1'b0);
        start_frame();
        checks++;
        if (busy !== 1'b1 || pix_valid !== 1'b0)
            $display("FAIL lat_cycle0: busy=%b valid=%b, required busy=1 valid=0", busy, pix_valid);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (pix_valid !== 1'b0) $display("FAIL lat_cycle1: valid=%b, required 0", pix_valid);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== 8'h00)
            $display("FAIL lat_cycle2: valid=%b sof=%b data=%h, required 1/1/00", pix_valid, pix_sof, pix_data);
        else passes++;
        wait_done(N + 100, 1'b0, ok);
        checks++;
        if (!ok) $display("FAIL basic_timeout: done=%b, required a done pulse", done);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_idle: done=%b busy=%b, required 0/0", done, busy);
        else passes++;
        checks++;
        if (xfer_cnt - x0 !== N || rd_cnt - rd0 !== N || done_cnt - dn0 !== 1)
            $display("FAIL basic_counts: xfers=%0d reads=%0d dones=%0d, required %0d/%0d/1", xfer_cnt - x0, rd_cnt - rd0, done_cnt - dn0, N, N);
        else passes++;
        checks++;
        if (sb.size() !== 0) $display("FAIL basic_sb_left: %0d bytes, required 0", sb.size());
        else passes++;
    endtask

    task automatic test_random_ready();
        int dn0, x0;
        bit ok;
        dn0 = done_cnt; x0 = xfer_cnt;
        push_frame(1'b0);
        pix_ready = 1'b0;
        start_frame();
        wait_done(4 * N, 1'b1, ok);
        checks++;
        if (!ok) $display("FAIL random_timeout: done=%b, required a done pulse", done);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (xfer_cnt - x0 !== N || done_cnt - dn0 !== 1 || sb.size() !== 0)
            $display("FAIL random_counts: xfers=%0d dones=%0d left=%0d, required %0d/1/0", xfer_cnt - x0, done_cnt - dn0, sb.size(), N);
        else passes++;
    endtask

    task automatic test_stall();
        int rd0, x0;
        bit ok, seen;
        rd0 = rd_cnt; x0 = xfer_cnt;
        push_frame(1'b0);
        pix_ready = 1'b0;
        start_frame();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pix_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen) $display("FAIL stall_first_valid: valid=%b, required 1", pix_valid);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== 8'h00)
                $display("FAIL stall_byte0: valid=%b sof=%b data=%h, required 1/1/00", pix_valid, pix_sof, pix_data);
            else passes++;
        end
        checks++;
        if (rd_cnt - rd0 !== 2 || xfer_cnt - x0 !== 0)
            $display("FAIL stall_outstanding: reads=%0d xfers=%0d, required 2/0", rd_cnt - rd0, xfer_cnt - x0);
        else passes++;
        pix_ready = 1'b1;
        wait_done(N + 100, 1'b0, ok);
        checks++;
        if (!ok || sb.size() !== 0)
            $display("FAIL stall_resume: done_seen=%b left=%0d, required 1/0", ok, sb.size());
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int dn0, x0;
        bit ok;
        dn0 = done_cnt; x0 = xfer_cnt;
        push_frame(1'b0);
        pix_ready = 1'b1;
        start_frame();
        ok = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk); #1;
            if (xfer_cnt - x0 >= 501) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) $display("FAIL midreset_progress: xfers=%0d, required 501", xfer_cnt - x0);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if ({pix_valid, pix_sof, pix_eol, pix_eof, mem_rd_en, busy, done} !== 7'b0 || pix_data !== 8'h00)
            $display("FAIL midreset_outputs: ctrl=%b data=%h, required 0", {pix_valid, pix_sof, pix_eol, pix_eof, mem_rd_en, busy, done}, pix_data);
        else passes++;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt - dn0 !== 0 || busy !== 1'b0)
            $display("FAIL midreset_no_done: dones=%0d busy=%b, required 0/0", done_cnt - dn0, busy);
        else passes++;
        x0 = xfer_cnt;
        push_frame(1'b0);
        start_frame();
        wait_done(N + 100, 1'b0, ok);
        checks++;
        if (!ok || xfer_cnt - x0 !== N || sb.size() !== 0)
            $display("FAIL midreset_refill: done_seen=%b xfers=%0d left=%0d, required 1/%0d/0", ok, xfer_cnt - x0, sb.size(), N);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int dn0, x0;
        bit ok;
        dn0 = done_cnt; x0 = xfer_cnt;
        push_frame(1'b0);
        pix_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk); #1;
            if (xfer_cnt - x0 >= 300) break;
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(N + 100, 1'b0, ok);
        checks++;
        if (!ok) $display("FAIL restart_timeout: done=%b, required a done pulse", done);
        else passes++;
        // Start during the DONE cycle must not launch another frame.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL start_in_done: busy=%b, required 0", busy);
        else passes++;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (xfer_cnt - x0 !== N || done_cnt - dn0 !== 1 || sb.size() !== 0 || busy !== 1'b0)
            $display("FAIL restart_counts: xfers=%0d dones=%0d left=%0d busy=%b, required %0d/1/0/0", xfer_cnt - x0, done_cnt - dn0, sb.size(), busy, N);
        else passes++;
    endtask

    task automatic test_pattern();
        int rd0, x0;
        bit ok;
        rd0 = rd_cnt; x0 = xfer_cnt;
`ifdef IMG_TEST_PATTERN_EN
        push_frame(1'b1);
`else
        push_frame(1'b0);
`endif
        pattern_en = 1'b1;
        pix_ready = 1'b1;
        start_frame();
        pattern_en = 1'b0;
        wait_done(N + 100, 1'b0, ok);
        checks++;
        if (!ok || xfer_cnt - x0 !== N || sb.size() !== 0)
            $display("FAIL pattern_frame: done_seen=%b xfers=%0d left=%0d, required 1/%0d/0", ok, xfer_cnt - x0, sb.size(), N);
        else passes++;
        checks++;
`ifdef IMG_TEST_PATTERN_EN
        if (rd_cnt - rd0 !== 0) $display("FAIL pattern_reads: reads=%0d, required 0", rd_cnt - rd0);
        else passes++;
`else
        if (rd_cnt - rd0 !== N) $display("FAIL pattern_reads: reads=%0d, required %0d", rd_cnt - rd0, N);
        else passes++;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pattern_en = 1'b0;
        pix_ready  = 1'b0;
        test_reset();
        test_basic_frame();
        test_random_ready();
        test_stall();
        test_reset_mid_frame();
        test_start_ignored();
        test_pattern();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
